// File: rtl/fetch_redirect_if.sv
// Fetch-redirect bundle: branch predictor, icache request/response and decoder handoff.
// master = the redirect controller, slave = its surrounding pipeline.
interface fetch_redirect_if;
  logic        rdy_in;
  logic        fail_valid;
  logic [31:0] fail_addr;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic        fetch_ready;
  logic        inst_valid;
  logic        stall_in;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        flush_out;
  logic [31:0] mispredict_cnt;

  modport master (
    input  rdy_in, fail_valid, fail_addr, pred_taken, pred_addr,
           fetch_ready, inst_valid, stall_in,
    output fetch_req, fetch_addr, dec_valid, dec_pc, flush_out, mispredict_cnt
  );

  modport slave (
    output rdy_in, fail_valid, fail_addr, pred_taken, pred_addr,
           fetch_ready, inst_valid, stall_in,
    input  fetch_req, fetch_addr, dec_valid, dec_pc, flush_out, mispredict_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: one outstanding icache request, predictor-steered next PC,
// and mispredict redirect with a timed fetch hold and stale-response dropping.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  fetch_redirect_if.master  bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FLUSH} state_t;

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_dec_valid, w_dec_valid_nxt;
  logic [31:0] r_dec_pc, w_dec_pc_nxt;
  logic        r_flush, w_flush_nxt;
  logic [31:0] r_mcnt, w_mcnt_nxt;
  logic        w_fetch_req;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_cnt       <= 4'd0;
      r_drop      <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec_pc    <= 32'h0;
      r_flush     <= 1'b0;
      r_mcnt      <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drop      <= w_drop_nxt;
      r_dec_valid <= w_dec_valid_nxt;
      r_dec_pc    <= w_dec_pc_nxt;
      r_flush     <= w_flush_nxt;
      r_mcnt      <= w_mcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_cnt_nxt       = r_cnt;
    w_drop_nxt      = r_drop;
    w_dec_valid_nxt = 1'b0;
    w_dec_pc_nxt    = r_dec_pc;
    w_flush_nxt     = 1'b0;
    w_mcnt_nxt      = r_mcnt;
    w_fetch_req     = (r_state == S_REQ) && bus.rdy_in && bus.fetch_ready &&
                      !bus.stall_in && !bus.fail_valid;

    if (bus.rdy_in) begin
      if (bus.fail_valid) begin
        w_pc_nxt    = word_align(bus.fail_addr);
        w_flush_nxt = 1'b1;
        w_cnt_nxt   = FLUSH_LD;
        w_state_nxt = S_FLUSH;
        w_mcnt_nxt  = sat_inc(r_mcnt);
        // A response arriving with the redirect is swallowed here; an in-flight one must be dropped later.
        if (bus.inst_valid)
          w_drop_nxt = 1'b0;
        else if (r_state == S_WAIT)
          w_drop_nxt = 1'b1;
      end else begin
        unique case (r_state)
          S_REQ: begin
            if (w_fetch_req) w_state_nxt = S_WAIT;
          end
          S_WAIT: begin
            if (bus.inst_valid) begin
              w_dec_valid_nxt = 1'b1;
              w_dec_pc_nxt    = r_pc;
              w_pc_nxt        = bus.pred_taken ? word_align(bus.pred_addr) : r_pc + 32'd4;
              w_state_nxt     = S_REQ;
            end
          end
          S_FLUSH: begin
            if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
            if (bus.inst_valid) w_drop_nxt = 1'b0;
            // Hold ends after FLUSH_CYCLES cycles, stretched until any stale response has been seen.
            if ((r_cnt <= 4'd1) && (!r_drop || bus.inst_valid)) w_state_nxt = S_REQ;
          end
          default: w_state_nxt = S_REQ;
        endcase
      end
    end
  end

  assign bus.fetch_req      = w_fetch_req;
  assign bus.fetch_addr     = r_pc;
  assign bus.dec_valid      = r_dec_valid;
  assign bus.dec_pc         = r_dec_pc;
  assign bus.flush_out      = r_flush;
  assign bus.mispredict_cnt = r_mcnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: sequential fetch, prediction, redirect,
// stale-response drop, PC wrap, pause, counter saturation and mid-request reset.
module tb_fetch_redirect_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic [31:0] exp_mcnt;

  fetch_redirect_if bus();

  fetch_redirect_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy_in      = 1'b1;
    bus.fail_valid  = 1'b0;
    bus.fail_addr   = 32'h0;
    bus.pred_taken  = 1'b0;
    bus.pred_addr   = 32'h0;
    bus.fetch_ready = 1'b1;
    bus.inst_valid  = 1'b0;
    bus.stall_in    = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_addr got %h expected %h", bus.fetch_addr, 32'h0); end
    n_chk++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got %b expected 0", bus.dec_valid); end
    n_chk++; if (bus.dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_dec_pc got %h expected 0", bus.dec_pc); end
    n_chk++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b expected 0", bus.flush_out); end
    n_chk++; if (bus.mispredict_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_mcnt got %h expected 0", bus.mispredict_cnt); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req got %b expected 1", bus.fetch_req); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d] got %b expected 1", i, bus.fetch_req); end
      n_chk++; if (bus.fetch_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h expected %h", i, bus.fetch_addr, 32'(4 * i)); end
      if (i > 0) begin
        n_chk++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL seq_dec_valid[%0d] got %b expected 1", i, bus.dec_valid); end
        n_chk++; if (bus.dec_pc !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL seq_dec_pc[%0d] got %h expected %h", i, bus.dec_pc, 32'(4 * (i - 1))); end
      end
      cyc();
      bus.inst_valid = 1'b1;
      bus.pred_taken = 1'b0;
      bus.pred_addr  = 32'hDEAD_BEE0;
      #2;
      n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL seq_one_outstanding[%0d] got %b expected 0", i, bus.fetch_req); end
      n_chk++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL seq_dec_pulse[%0d] got %b expected 0", i, bus.dec_valid); end
      cyc();
      idle();
    end
    #2;
    n_chk++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL seq_last_dec_valid got %b expected 1", bus.dec_valid); end
    n_chk++; if (bus.dec_pc !== 32'h8) begin n_fail++; $display("FAIL seq_last_dec_pc got %h expected 8", bus.dec_pc); end
    n_chk++; if (bus.fetch_addr !== 32'hC) begin n_fail++; $display("FAIL seq_next_addr got %h expected c", bus.fetch_addr); end
  endtask

  task automatic test_fail_with_response();
    cyc();
    bus.inst_valid = 1'b1;
    bus.pred_taken = 1'b1;
    bus.pred_addr  = 32'h800;
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 32'h400;
    #2;
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL collide_req got %b expected 0", bus.fetch_req); end
    cyc();
    idle();
    exp_mcnt = 32'd1;
    #2;
    n_chk++; if (bus.flush_out !== 1'b1) begin n_fail++; $display("FAIL collide_flush got %b expected 1", bus.flush_out); end
    n_chk++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL collide_no_dec got %b expected 0", bus.dec_valid); end
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL collide_hold1 got %b expected 0", bus.fetch_req); end
    n_chk++; if (bus.mispredict_cnt !== exp_mcnt) begin n_fail++; $display("FAIL collide_mcnt got %h expected %h", bus.mispredict_cnt, exp_mcnt); end
    cyc();
    #2;
    n_chk++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL collide_flush_pulse got %b expected 0", bus.flush_out); end
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL collide_hold2 got %b expected 0", bus.fetch_req); end
    n_chk++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL collide_no_dec2 got %b expected 0", bus.dec_valid); end
    cyc();
    #2;
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL collide_resume_req got %b expected 1", bus.fetch_req); end
    n_chk++; if (bus.fetch_addr !== 32'h400) begin n_fail++; $display("FAIL collide_resume_addr got %h expected 400", bus.fetch_addr); end
  endtask

  task automatic test_pred_taken();
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 32'h102;
    #2;
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL pred_fail_blocks_req got %b expected 0", bus.fetch_req); end
    cyc();
    idle();
    exp_mcnt = 32'd2;
    #2;
    n_chk++; if (bus.flush_out !== 1'b1) begin n_fail++; $display("FAIL pred_flush got %b expected 1", bus.flush_out); end
    cyc();
    cyc();
    #2;
    n_chk++; if (bus.fetch_addr !== 32'h100) begin n_fail++; $display("FAIL pred_align_addr got %h expected 100", bus.fetch_addr); end
    cyc();
    bus.inst_valid = 1'b1;
    bus.pred_taken = 1'b1;
    bus.pred_addr  = 32'h203;
    cyc();
    idle();
    #2;
    n_chk++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL pred_dec_valid got %b expected 1", bus.dec_valid); end
    n_chk++; if (bus.dec_pc !== 32'h100) begin n_fail++; $display("FAIL pred_dec_pc got %h expected 100", bus.dec_pc); end
    n_chk++; if (bus.fetch_addr !== 32'h200) begin n_fail++; $display("FAIL pred_target got %h expected 200", bus.fetch_addr); end
    n_chk++; if (bus.mispredict_cnt !== exp_mcnt) begin n_fail++; $display("FAIL pred_mcnt got %h expected %h", bus.mispredict_cnt, exp_mcnt); end
  endtask

  task automatic test_drop_pending();
    cyc();
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 32'h500;
    cyc();
    idle();
    exp_mcnt = 32'd3;
    #2;
    n_chk++; if (bus.flush_out !== 1'b1) begin n_fail++; $display("FAIL drop_flush got %b expected 1", bus.flush_out); end
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL drop_hold_f1 got %b expected 0", bus.fetch_req); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      #2;
      n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL drop_hold_f%0d got %b expected 0", k + 2, bus.fetch_req); end
    end
    cyc();
    bus.inst_valid = 1'b1;
    bus.pred_taken = 1'b1;
    bus.pred_addr  = 32'h900;
    #2;
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL drop_hold_f4 got %b expected 0", bus.fetch_req); end
    cyc();
    idle();
    #2;
    n_chk++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_dec got %b expected 0", bus.dec_valid); end
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL drop_resume_req got %b expected 1", bus.fetch_req); end
    n_chk++; if (bus.fetch_addr !== 32'h500) begin n_fail++; $display("FAIL drop_resume_addr got %h expected 500", bus.fetch_addr); end
    n_chk++; if (bus.mispredict_cnt !== exp_mcnt) begin n_fail++; $display("FAIL drop_mcnt got %h expected %h", bus.mispredict_cnt, exp_mcnt); end
  endtask

  task automatic test_wrap_pause();
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 32'hFFFF_FFFF;
    cyc();
    idle();
    exp_mcnt = 32'd4;
    cyc();
    cyc();
    #2;
    n_chk++; if (bus.fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_start_addr got %h expected fffffffc", bus.fetch_addr); end
    cyc();
    bus.rdy_in     = 1'b0;
    bus.inst_valid = 1'b1;
    bus.pred_taken = 1'b1;
    bus.pred_addr  = 32'h600;
    bus.fail_valid = 1'b1;
    bus.fail_addr  = 32'h700;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL pause_req[%0d] got %b expected 0", k, bus.fetch_req); end
      n_chk++; if (bus.fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL pause_pc[%0d] got %h expected fffffffc", k, bus.fetch_addr); end
      n_chk++; if (bus.dec_valid !== 1'b0 || bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL pause_pulses[%0d] got dec=%b flush=%b expected 0/0", k, bus.dec_valid, bus.flush_out); end
      n_chk++; if (bus.mispredict_cnt !== exp_mcnt) begin n_fail++; $display("FAIL pause_mcnt[%0d] got %h expected %h", k, bus.mispredict_cnt, exp_mcnt); end
      cyc();
    end
    idle();
    bus.inst_valid = 1'b1;
    #2;
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL pause_still_wait got %b expected 0", bus.fetch_req); end
    cyc();
    idle();
    #2;
    n_chk++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_dec_valid got %b expected 1", bus.dec_valid); end
    n_chk++; if (bus.dec_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_dec_pc got %h expected fffffffc", bus.dec_pc); end
    n_chk++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr got %h expected 0", bus.fetch_addr); end
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL wrap_resume_req got %b expected 1", bus.fetch_req); end
    n_chk++; if (bus.mispredict_cnt !== exp_mcnt) begin n_fail++; $display("FAIL wrap_mcnt got %h expected %h", bus.mispredict_cnt, exp_mcnt); end
  endtask

  task automatic test_saturation();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE;
    want[1] = 32'hFFFF_FFFF;
    want[2] = 32'hFFFF_FFFF;
    force dut.r_mcnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_mcnt;
    for (int k = 0; k < 3; k++) begin
      bus.fail_valid = 1'b1;
      bus.fail_addr  = 32'h1000 + 32'(16 * k);
      cyc();
      #2;
      n_chk++; if (bus.flush_out !== 1'b1) begin n_fail++; $display("FAIL sat_flush[%0d] got %b expected 1", k, bus.flush_out); end
      n_chk++; if (bus.mispredict_cnt !== want[k]) begin n_fail++; $display("FAIL sat_mcnt[%0d] got %h expected %h", k, bus.mispredict_cnt, want[k]); end
    end
    idle();
    cyc();
    #2;
    n_chk++; if (bus.flush_out !== 1'b0 || bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL sat_hold got flush=%b req=%b expected 0/0", bus.flush_out, bus.fetch_req); end
    cyc();
    #2;
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL sat_resume_req got %b expected 1", bus.fetch_req); end
    n_chk++; if (bus.fetch_addr !== 32'h1020) begin n_fail++; $display("FAIL sat_reload_addr got %h expected 1020", bus.fetch_addr); end
  endtask

  task automatic test_reset_mid();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    exp_mcnt = 32'h0;
    n_chk++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got %h expected 0", bus.fetch_addr); end
    n_chk++; if (bus.mispredict_cnt !== exp_mcnt) begin n_fail++; $display("FAIL midrst_mcnt got %h expected 0", bus.mispredict_cnt); end
    @(negedge clk);
    rst = 1'b0;
    bus.inst_valid = 1'b1;
    bus.pred_taken = 1'b1;
    bus.pred_addr  = 32'h3000;
    #2;
    n_chk++; if (bus.fetch_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req got %b expected 1", bus.fetch_req); end
    cyc();
    idle();
    #2;
    n_chk++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_dec got %b expected 0", bus.dec_valid); end
    n_chk++; if (bus.fetch_req !== 1'b0) begin n_fail++; $display("FAIL midrst_outstanding got %b expected 0", bus.fetch_req); end
    n_chk++; if (bus.fetch_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_pc got %h expected 0", bus.fetch_addr); end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    exp_mcnt = 32'h0;
    rst      = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    test_reset();
    test_sequential();
    test_fail_with_response();
    test_pred_taken();
    test_drop_pending();
    test_wrap_pause();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Parameters
REQ-001 SHALL have parameter RESET_PC, default 32'h0, meaning PC loaded at reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1-15, meaning fetch-hold cycles after a mispredict.

Interface
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  global enable; low = pause.
REQ-006 SHALL have port fail_valid  input  1  mispredict from branch predictor.
REQ-007 SHALL have port fail_addr  input  32  corrected PC.
REQ-008 SHALL have port pred_taken  input  1  predictor branch decision for the instruction in the current response.
REQ-009 SHALL have port pred_addr  input  32  predicted target.
REQ-010 SHALL have port fetch_ready  input  1  icache accepts a request.
REQ-011 SHALL have port inst_valid  input  1  icache response valid.
REQ-012 SHALL have port stall_in  input  1  downstream full.
REQ-013 SHALL have port fetch_req  output  1  fetch request.
REQ-014 SHALL have port fetch_addr  output  32  request address.
REQ-015 SHALL have port dec_valid  output  1  instruction handed to decoder.
REQ-016 SHALL have port dec_pc  output  32  PC of handed instruction.
REQ-017 SHALL have port flush_out  output  1  pipeline flush pulse.
REQ-018 SHALL have port mispredict_cnt  output  32  saturating count of accepted mispredicts.

Function
REQ-019 SHALL implement states S_REQ, S_WAIT, S_FLUSH, held in a register pc (32b).
REQ-020 In S_REQ: fetch_req = rdy_in & fetch_ready & !stall_in & !fail_valid (combinational); fetch_addr = pc at all times.
REQ-021 When fetch_req=1: request accepted that cycle; next state S_WAIT.
REQ-022 In S_WAIT, on inst_valid with no drop pending: dec_valid<=1 and dec_pc<=pc next cycle; pc<=pred_taken ? pred_addr : pc+4; next state S_REQ.
REQ-023 pc+4 SHALL wrap modulo 2^32; bits [1:0] of fail_addr/pred_addr SHALL be forced to 00 on load.
REQ-024 dec_valid SHALL be a one-cycle pulse; pred_taken/pred_addr SHALL be ignored when inst_valid=0.
REQ-025 fail_valid (rdy_in=1), in any state: pc<=fail_addr; flush_out<=1 for exactly one cycle; counter<=FLUSH_CYCLES; next state S_FLUSH; mispredict_cnt+1, saturating at 32'hFFFFFFFF.
REQ-026 fail_valid SHALL take priority over simultaneous inst_valid; that response is discarded (no dec_valid).
REQ-027 fail_valid while in S_WAIT with no response that cycle SHALL set drop_pending; the next inst_valid is discarded, clearing drop_pending.
REQ-028 In S_FLUSH: counter decrements each cycle; at 0 go to S_REQ only when drop_pending=0, else remain until the stale response is discarded.
REQ-029 fail_valid during S_FLUSH SHALL reload pc and counter, re-pulse flush_out and increment mispredict_cnt.
REQ-030 inst_valid in S_REQ or S_FLUSH with drop_pending=0 SHALL be ignored.
REQ-031 rdy_in=0: all registers hold, fetch_req=0, dec_valid and flush_out forced 0 next cycle; fail_valid and inst_valid ignored.
REQ-032 At most one outstanding fetch request at any time.

Reset
REQ-033 rst_in=1 SHALL asynchronously set state S_REQ, pc=RESET_PC, dec_valid=0, dec_pc=0, flush_out=0, mispredict_cnt=0, counter=0, drop_pending=0.
REQ-034 Reset asserted mid-request SHALL abandon the outstanding request with no dec_valid afterwards; first post-reset fetch_addr=RESET_PC.

Verification
REQ-035 Reset release, fetch_ready=1, each request answered next cycle, pred_taken=0 -> fetch_addr 0,4,8; dec_pc 0,4,8.
REQ-036 Response for pc=0x100 with pred_taken=1, pred_addr=0x203 -> dec_pc=0x100, next fetch_addr=0x200.
REQ-037 fail_valid, fail_addr=0x400 in the same cycle as inst_valid -> no dec_valid, one-cycle flush_out, fetch_req low 2 cycles, then fetch_addr=0x400, mispredict_cnt=1.
REQ-038 fail_valid in S_WAIT, response 4 cycles later -> response dropped, S_FLUSH held until then, next fetch_addr=fail_addr.
REQ-039 pc=0xFFFFFFFC, not taken -> next fetch_addr=0x0; rdy_in low 3 cycles mid-S_WAIT -> state, pc and outputs frozen; resume normally.
REQ-040 mispredict_cnt preloaded to 0xFFFFFFFF via repeated fail_valid -> remains 0xFFFFFFFF.
